// File: rtl/poseidon_input_framer.sv
// poseidon_input_framer
// Packs a stream of field-element beats into fixed-size permutation frames
// (STATE_SIZE elements each) and queues committed frames in a small
// first-word-fall-through FIFO of FIFO_DEPTH slots.
//
// Optional feature macro: POSEIDON_FRAMER_PAD_EN
//   defined   : a message ending before the frame is full is committed with
//               the unfilled elements zero and count = elements received.
//   undefined : such a short message is dropped and io_error pulses.
//
// An overlong message (no last on the final frame element) commits the full
// frame, pulses io_error and discards beats up to and including the next last.

module poseidon_input_framer #(
    parameter int ELEM_WIDTH = 255,
    parameter int STATE_SIZE = 9,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             io_input_valid,
    output logic                             io_input_ready,
    input  logic                             io_input_last,
    input  logic [ELEM_WIDTH-1:0]            io_input_payload,
    output logic                             io_output_valid,
    input  logic                             io_output_ready,
    output logic [ELEM_WIDTH*STATE_SIZE-1:0] io_output_payload,
    output logic [4:0]                       io_output_count,
    output logic                             io_error,
    output logic [31:0]                      io_frame_count
);

    localparam int         FRAME_W  = ELEM_WIDTH * STATE_SIZE;
    localparam int         PTR_W    = $clog2(FIFO_DEPTH);
    localparam int         OCC_W    = PTR_W + 1;
    localparam logic [4:0] LAST_IDX = 5'(STATE_SIZE - 1);
    localparam logic [4:0] FULL_CNT = 5'(STATE_SIZE);

    typedef enum logic [0:0] {
        ST_FILL    = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [4:0]         r_index;
    logic [FRAME_W-1:0] r_stage;

    logic [FRAME_W-1:0] r_fifo_data  [FIFO_DEPTH];
    logic [4:0]         r_fifo_count [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;

    logic               r_error;
    logic [31:0]        r_frame_count;

    logic               w_ready;
    logic               w_accept;
    logic               w_commit;
    logic               w_drop;
    logic               w_err_set;
    logic [4:0]         w_commit_count;
    logic               w_at_last_idx;
    logic               w_fifo_full;
    logic               w_valid;
    logic               w_push;
    logic               w_pop;
    logic [FRAME_W-1:0] w_frame;

    assign w_at_last_idx = (r_index == LAST_IDX);
    assign w_fifo_full   = (r_occ == OCC_W'(FIFO_DEPTH));
    assign w_valid       = (r_occ != {OCC_W{1'b0}});
    assign w_push        = w_commit;
    assign w_pop         = w_valid && io_output_ready;

    assign io_input_ready  = w_ready;
    assign io_output_valid = w_valid;
    assign io_error        = r_error;
    assign io_frame_count  = r_frame_count;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: overflow enters DISCARD, a last beat in DISCARD returns to FILL.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_accept && w_at_last_idx && !io_input_last) begin
                    w_state_next = ST_DISCARD;
                end else begin
                    w_state_next = ST_FILL;
                end
            end
            ST_DISCARD: begin
                if (w_accept && io_input_last) begin
                    w_state_next = ST_FILL;
                end else begin
                    w_state_next = ST_DISCARD;
                end
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
    end

    // FSM outputs: handshake, commit/drop decision and error request per beat.
    always_comb begin
        w_ready        = 1'b0;
        w_accept       = 1'b0;
        w_commit       = 1'b0;
        w_drop         = 1'b0;
        w_err_set      = 1'b0;
        w_commit_count = 5'd0;
        case (r_state)
            ST_FILL: begin
                w_ready  = !w_fifo_full;
                w_accept = io_input_valid && !w_fifo_full;
                if (w_accept) begin
                    if (w_at_last_idx) begin
                        w_commit       = 1'b1;
                        w_commit_count = FULL_CNT;
                        w_err_set      = !io_input_last;
                    end else if (io_input_last) begin
`ifdef POSEIDON_FRAMER_PAD_EN
                        w_commit       = 1'b1;
                        w_commit_count = r_index + 5'd1;
`else
                        w_drop         = 1'b1;
                        w_err_set      = 1'b1;
`endif
                    end else begin
                        w_commit = 1'b0;
                    end
                end else begin
                    w_commit = 1'b0;
                end
            end
            ST_DISCARD: begin
                w_ready  = 1'b1;
                w_accept = io_input_valid;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // Frame being committed: staging with the current beat merged into its slot.
    always_comb begin
        w_frame = r_stage;
        w_frame[int'(r_index)*ELEM_WIDTH +: ELEM_WIDTH] = io_input_payload;
    end

    // Staging buffer and element index; cleared whenever a message ends in FILL.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_index <= 5'd0;
            r_stage <= '0;
        end else if (w_accept && (r_state == ST_FILL)) begin
            if (w_commit || w_drop) begin
                r_index <= 5'd0;
                r_stage <= '0;
            end else begin
                r_index <= r_index + 5'd1;
                r_stage[int'(r_index)*ELEM_WIDTH +: ELEM_WIDTH] <= io_input_payload;
            end
        end else begin
            r_index <= r_index;
            r_stage <= r_stage;
        end
    end

    // FIFO slot storage; contents are masked at the output while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= w_frame;
            r_fifo_count[r_wr_ptr] <= w_commit_count;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_occ    <= {OCC_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Error pulse (one cycle after the offending beat) and popped-frame counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_error       <= 1'b0;
            r_frame_count <= 32'd0;
        end else begin
            r_error <= w_err_set;
            if (w_pop) begin
                r_frame_count <= r_frame_count + 32'd1;
            end else begin
                r_frame_count <= r_frame_count;
            end
        end
    end

    // Head-of-FIFO view; forced to zero while the FIFO is empty.
    always_comb begin
        if (w_valid) begin
            io_output_payload = r_fifo_data[r_rd_ptr];
            io_output_count   = r_fifo_count[r_rd_ptr];
        end else begin
            io_output_payload = '0;
            io_output_count   = 5'd0;
        end
    end

endmodule

// File: tb/tb_poseidon_input_framer.sv
// Testbench for poseidon_input_framer (default parameters).
// Expected frames come from a small message model in the bench and are queued
// as messages are driven; frames leaving the DUT are popped and compared.

module tb_poseidon_input_framer;

    localparam int EW = 255;
    localparam int S  = 9;
    localparam int D  = 2;
    localparam int FW = EW * S;
    localparam int NV = 8;

    typedef struct {
        logic [FW-1:0] payload;
        logic [4:0]    count;
    } exp_t;

    typedef struct {
        int n_beats;
        int base;
        int exp_frames;
        int exp_errs;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_input_valid;
    logic          io_input_ready;
    logic          io_input_last;
    logic [EW-1:0] io_input_payload;
    logic          io_output_valid;
    logic          io_output_ready;
    logic [FW-1:0] io_output_payload;
    logic [4:0]    io_output_count;
    logic          io_error;
    logic [31:0]   io_frame_count;

    int   checks   = 0;
    int   errors   = 0;
    int   pop_seen = 0;
    int   err_seen = 0;
    int   exp_fc   = 0;
    logic ready_s  = 1'b0;
    exp_t exp_q[$];
    vec_t vecs[NV];

    poseidon_input_framer #(
        .ELEM_WIDTH (EW),
        .STATE_SIZE (S),
        .FIFO_DEPTH (D)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .io_input_valid    (io_input_valid),
        .io_input_ready    (io_input_ready),
        .io_input_last     (io_input_last),
        .io_input_payload  (io_input_payload),
        .io_output_valid   (io_output_valid),
        .io_output_ready   (io_output_ready),
        .io_output_payload (io_output_payload),
        .io_output_count   (io_output_count),
        .io_error          (io_error),
        .io_frame_count    (io_frame_count)
    );

    always #5 clk = ~clk;

    function automatic logic [EW-1:0] elem_val(input int base, input int i);
        logic [EW-1:0] v;
        v = EW'(base + i);
        v = v | (v << (EW - 32));
        return v;
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic cmp_payload(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
        bit reported;
        reported = 1'b0;
        checks++;
        if (act !== req) begin
            errors++;
            for (int k = 0; k < S; k++) begin
                if (!reported && (act[k*EW +: EW] !== req[k*EW +: EW])) begin
                    reported = 1'b1;
                    $display("FAIL %s elem %0d: got %h, required %h", name, k,
                             act[k*EW +: EW], req[k*EW +: EW]);
                end
            end
        end
    endtask

    // One clock: sample outputs on the falling edge, return 1 unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        ready_s = io_input_ready;
        if (!reset) begin
            if (io_error) err_seen++;
            if (io_output_valid && io_output_ready) begin
                pop_seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: got frame with count %0d, required none", io_output_count);
                end else begin
                    e = exp_q.pop_front();
                    chk("frame_count_field", io_output_count, e.count);
                    cmp_payload("frame_payload", io_output_payload, e.payload);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [EW-1:0] d, input logic l);
        int g;
        g = 0;
        io_input_valid   = 1'b1;
        io_input_payload = d;
        io_input_last    = l;
        tick();
        while (!ready_s && g < 200) begin
            tick();
            g++;
        end
        if (!ready_s) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: got ready 0 for %0d cycles, required 1", g);
        end
        io_input_valid = 1'b0;
        io_input_last  = 1'b0;
    endtask

    // Drive a message and queue the frames the model says it must produce.
    task automatic send_msg(input int n, input int base, input bit with_last, input bit gaps);
        logic [FW-1:0] stage;
        logic [EW-1:0] v;
        int            idx;
        bit            disc;
        bit            l;
        exp_t          e;
        stage = '0;
        idx   = 0;
        disc  = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = elem_val(base, i);
            l = with_last && (i == n - 1);
            if (disc) begin
                if (l) disc = 1'b0;
            end else begin
                stage[idx*EW +: EW] = v;
                if (idx == S - 1) begin
                    e.payload = stage;
                    e.count   = 5'(S);
                    exp_q.push_back(e);
                    if (!l) disc = 1'b1;
                    idx   = 0;
                    stage = '0;
                end else if (l) begin
`ifdef POSEIDON_FRAMER_PAD_EN
                    e.payload = stage;
                    e.count   = 5'(idx + 1);
                    exp_q.push_back(e);
`endif
                    idx   = 0;
                    stage = '0;
                end else begin
                    idx++;
                end
            end
            send_beat(v, l);
            if (gaps) repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    task automatic drain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        tick();
        tick();
        chk({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int   p0;
        int   e0;
        exp_t e;
        logic [FW-1:0] head;

        vecs[0] = '{n_beats: 11, base: 32'h100, exp_frames: 1, exp_errs: 1};
`ifdef POSEIDON_FRAMER_PAD_EN
        vecs[1] = '{n_beats: 4,  base: 32'hA,   exp_frames: 1, exp_errs: 0};
`else
        vecs[1] = '{n_beats: 4,  base: 32'hA,   exp_frames: 0, exp_errs: 1};
`endif
        vecs[2] = '{n_beats: 9,  base: 32'h200, exp_frames: 1, exp_errs: 0};
`ifdef POSEIDON_FRAMER_PAD_EN
        vecs[3] = '{n_beats: 1,  base: 32'h55,  exp_frames: 1, exp_errs: 0};
        vecs[5] = '{n_beats: 8,  base: 32'h400, exp_frames: 1, exp_errs: 0};
`else
        vecs[3] = '{n_beats: 1,  base: 32'h55,  exp_frames: 0, exp_errs: 1};
        vecs[5] = '{n_beats: 8,  base: 32'h400, exp_frames: 0, exp_errs: 1};
`endif
        vecs[4] = '{n_beats: 18, base: 32'h300, exp_frames: 1, exp_errs: 1};
        vecs[6] = '{n_beats: 10, base: 32'h500, exp_frames: 1, exp_errs: 1};
        vecs[7] = '{n_beats: 9,  base: 32'h600, exp_frames: 1, exp_errs: 0};

        reset            = 1'b1;
        io_input_valid   = 1'b0;
        io_input_last    = 1'b0;
        io_input_payload = '0;
        io_output_ready  = 1'b0;
        @(posedge clk);
        #1;
        repeat (3) tick();

        // Reset state.
        chk("rst_valid", io_output_valid, 0);
        chk("rst_count", io_output_count, 0);
        chk("rst_payload_zero", (io_output_payload == '0) ? 1 : 0, 1);
        chk("rst_error", io_error, 0);
        chk("rst_frame_count", io_frame_count, 0);
        reset = 1'b0;
        chk("rst_ready_after", io_input_ready, 1);

        // First frame: valid appears the cycle after the 9th beat and holds while stalled.
        send_msg(8, 1, 1'b0, 1'b0);
        chk("first_valid_before_last", io_output_valid, 0);
        send_beat(elem_val(1, 8), 1'b1);
        e.payload = '0;
        for (int k = 0; k < S; k++) e.payload[k*EW +: EW] = elem_val(1, k);
        e.count = 5'(S);
        exp_q.push_back(e);
        chk("first_valid_after_last", io_output_valid, 1);
        chk("first_count", io_output_count, S);
        head = io_output_payload;
        repeat (3) tick();
        cmp_payload("first_payload_stable", io_output_payload, head);
        chk("first_valid_held", io_output_valid, 1);
        io_output_ready = 1'b1;
        drain("first");
        exp_fc = 1;
        chk("first_pops", pop_seen, 1);
        chk("first_frame_count", io_frame_count, exp_fc);

        // Table-driven messages with the consumer always ready.
        for (int v = 0; v < NV; v++) begin
            p0 = pop_seen;
            e0 = err_seen;
            send_msg(vecs[v].n_beats, vecs[v].base, 1'b1, 1'b1);
            drain($sformatf("vec%0d", v));
            exp_fc += vecs[v].exp_frames;
            chk($sformatf("vec%0d_frames", v), pop_seen - p0, vecs[v].exp_frames);
            chk($sformatf("vec%0d_errors", v), err_seen - e0, vecs[v].exp_errs);
            chk($sformatf("vec%0d_frame_count", v), io_frame_count, exp_fc);
        end

        // Backpressure: two frames fill the FIFO, the third waits for a pop.
        io_output_ready = 1'b0;
        p0 = pop_seen;
        send_msg(9, 32'h1000, 1'b1, 1'b0);
        chk("bp_ready_after_one", io_input_ready, 1);
        send_msg(9, 32'h2000, 1'b1, 1'b0);
        chk("bp_ready_full", io_input_ready, 0);
        chk("bp_valid_full", io_output_valid, 1);
        tick();
        chk("bp_ready_still_full", io_input_ready, 0);
        io_output_ready = 1'b1;
        send_msg(9, 32'h3000, 1'b1, 1'b0);
        drain("bp");
        exp_fc += 3;
        chk("bp_pops", pop_seen - p0, 3);
        chk("bp_frame_count", io_frame_count, exp_fc);

        // Reset mid-message with a frame queued.
        io_output_ready = 1'b0;
        send_msg(9, 32'h7000, 1'b1, 1'b0);
        send_msg(5, 32'h7100, 1'b0, 1'b0);
        chk("mid_valid_before_reset", io_output_valid, 1);
        reset = 1'b1;
        tick();
        tick();
        exp_q.delete();
        exp_fc = 0;
        reset  = 1'b0;
        chk("mid_valid", io_output_valid, 0);
        chk("mid_count", io_output_count, 0);
        chk("mid_payload_zero", (io_output_payload == '0) ? 1 : 0, 1);
        chk("mid_frame_count", io_frame_count, 0);
        chk("mid_ready", io_input_ready, 1);
        e0 = err_seen;
        repeat (3) tick();
        chk("mid_no_error", err_seen - e0, 0);
        chk("mid_still_empty", io_output_valid, 0);
        io_output_ready = 1'b1;
        p0 = pop_seen;
        send_msg(9, 32'h8000, 1'b1, 1'b0);
        drain("mid_after");
        exp_fc += 1;
        chk("mid_after_pops", pop_seen - p0, 1);
        chk("mid_after_frame_count", io_frame_count, exp_fc);
        chk("mid_after_errors", err_seen - e0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/poseidon_input_framer.md
POSEIDON_INPUT_FRAMER -- requirements
Module: poseidon_input_framer

Interface
REQ-001 SHALL have parameter ELEM_WIDTH, default 255, field-element width in bits.
REQ-002 SHALL have parameter STATE_SIZE, default 9, elements per permutation frame (2..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 2, frame-slot count (power of 2, >=2).
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port io_input_valid, input, 1, element beat valid.
REQ-007 SHALL have port io_input_ready, output, 1, element beat accepted when high with valid.
REQ-008 SHALL have port io_input_last, input, 1, final element of the current message.
REQ-009 SHALL have port io_input_payload, input, ELEM_WIDTH, element value.
REQ-010 SHALL have port io_output_valid, output, 1, frame available at head of FIFO.
REQ-011 SHALL have port io_output_ready, input, 1, consumer accepts head frame.
REQ-012 SHALL have port io_output_payload, output, ELEM_WIDTH*STATE_SIZE, frame; element k at bits [k*ELEM_WIDTH +: ELEM_WIDTH].
REQ-013 SHALL have port io_output_count, output, 5, number of real (non-pad) elements in head frame.
REQ-014 SHALL have port io_error, output, 1, one-cycle pulse on malformed message.
REQ-015 SHALL have port io_frame_count, output, 32, total frames popped, wraps at 2^32.

Function
REQ-016 SHALL accept an input beat only on io_input_valid & io_input_ready (handshake); element index increments per beat from 0.
REQ-017 SHALL write beat k into staging element k; staging cleared to zero in the cycle a frame commits.
REQ-018 SHALL run states FILL and DISCARD; FILL is the reset state.
REQ-019 In FILL, io_input_ready SHALL equal (FIFO occupancy < FIFO_DEPTH); in DISCARD it SHALL be 1.
REQ-020 Beat with last at index STATE_SIZE-1 SHALL commit the frame with count STATE_SIZE, index returns to 0, stay FILL.
REQ-021 Beat at index STATE_SIZE-1 without last SHALL commit the frame (count STATE_SIZE), pulse io_error next cycle, enter DISCARD.
REQ-022 DISCARD SHALL drop beats without storing; beat with last returns to FILL, index 0.
REQ-023 Beat with last at index < STATE_SIZE-1 SHALL be handled per REQ-031/032.
REQ-024 Committed frame SHALL be visible (io_output_valid=1) the cycle after the commit beat; first-word-fall-through, payload and count stable while valid & !ready.
REQ-025 Pop on io_output_valid & io_output_ready; same-cycle push and pop SHALL both occur, occupancy unchanged.
REQ-026 Frames SHALL leave in commit order; io_frame_count increments by 1 per pop.

Reset
REQ-027 On reset: state FILL, index 0, staging zero, FIFO empty.
REQ-028 Reset values: io_output_valid 0, io_output_payload 0, io_output_count 0, io_error 0, io_frame_count 0; io_input_ready 1 the cycle after reset deasserts.
REQ-029 Reset mid-message SHALL discard the partial frame and all queued frames with no error pulse.

Configuration
REQ-030 Macro POSEIDON_FRAMER_PAD_EN SHALL select short-message handling.
REQ-031 With POSEIDON_FRAMER_PAD_EN defined: short message commits with unfilled elements zero, count = index+1, no error.
REQ-032 Without it: short message is dropped (no commit, staging cleared), io_error pulses, state stays FILL.

Verification
REQ-033 Reset, then 9 beats 1..9, last on 9th, ready=1 -> one frame, elem k = k+1, count 9, valid one cycle after 9th beat, io_frame_count 1.
REQ-034 Three full messages, io_output_ready=0, FIFO_DEPTH=2 -> io_input_ready falls after 2nd commit; raise ready -> frames pop in order, 3rd then accepted.
REQ-035 11 beats, last on 11th -> frame of first 9, one io_error pulse, beats 10-11 dropped, next message frames normally.
REQ-036 4 beats 0xA..0xD, last on 4th -> PAD_EN: count 4, elems 4..8 zero, no error; no PAD_EN: no frame, one error pulse.
REQ-037 Reset asserted after 5 beats of a message with 1 frame queued -> valid 0, count 0, next 9-beat message yields correct frame.
